// File: rtl/pifo_sched_pkg.sv
// Shared definitions for the root PIFO dequeue scheduler: root-word layout, FSM states
// and the gPFC pause comparison.
package pifo_sched_pkg;

    localparam int BUFFER_ADDR_WIDTH = 12;
    localparam int PIFO_RANK_WIDTH   = 18;
    localparam int PIFO_ROOT_WIDTH   = 32;
    localparam int CREDIT_WIDTH      = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_POP_WAIT = 2'd1,
        ST_ISSUE    = 2'd2
    } sched_state_e;

    // {valid[31], overflow[30], rank[29:12], addr[11:0]}
    typedef struct packed {
        logic                         valid;
        logic                         overflow;
        logic [PIFO_RANK_WIDTH-1:0]   rank;
        logic [BUFFER_ADDR_WIDTH-1:0] addr;
    } root_word_t;

    function automatic logic rank_paused(
        input logic                       gpfc_valid,
        input logic [PIFO_RANK_WIDTH-1:0] rank,
        input logic [PIFO_RANK_WIDTH-1:0] pause_rank
    );
        return gpfc_valid & (rank >= pause_rank);
    endfunction

endpackage

// File: rtl/pifo_root_dequeue_scheduler_if.sv
// Handshake bundle between the scheduler (master modport) and its bypass checker,
// calendar PIFO, gPFC source and packet-buffer read engine (slave modport).
interface pifo_root_dequeue_scheduler_if
    import pifo_sched_pkg::*;
#(
    parameter int CNT_WIDTH = 32
);
    logic                         s_bypass_valid;
    logic [PIFO_ROOT_WIDTH-1:0]   s_bypass_info;
    logic                         s_bypass_en;
    logic                         s_bypass_ready;

    logic [PIFO_ROOT_WIDTH-1:0]   s_cal_top;
    logic                         m_cal_pop;
    logic                         m_cal_ins_valid;
    logic [PIFO_ROOT_WIDTH-1:0]   m_cal_ins_info;
    logic                         s_cal_ins_ready;

    logic                         s_gpfc_valid;
    logic [PIFO_RANK_WIDTH-1:0]   s_gpfc_pause_rank;

    logic                         m_rd_valid;
    logic [BUFFER_ADDR_WIDTH-1:0] m_rd_addr;
    logic                         m_rd_src;
    logic                         m_rd_ready;
    logic                         s_rd_done;
    logic                         m_credit_err;

    logic [CNT_WIDTH-1:0]         m_stat_bypass;
    logic [CNT_WIDTH-1:0]         m_stat_cal;
    logic [CNT_WIDTH-1:0]         m_stat_pause;

    modport master (
        input  s_bypass_valid, s_bypass_info, s_bypass_en, s_cal_top, s_cal_ins_ready,
               s_gpfc_valid, s_gpfc_pause_rank, m_rd_ready, s_rd_done,
        output s_bypass_ready, m_cal_pop, m_cal_ins_valid, m_cal_ins_info,
               m_rd_valid, m_rd_addr, m_rd_src, m_credit_err,
               m_stat_bypass, m_stat_cal, m_stat_pause
    );

    modport slave (
        output s_bypass_valid, s_bypass_info, s_bypass_en, s_cal_top, s_cal_ins_ready,
               s_gpfc_valid, s_gpfc_pause_rank, m_rd_ready, s_rd_done,
        input  s_bypass_ready, m_cal_pop, m_cal_ins_valid, m_cal_ins_info,
               m_rd_valid, m_rd_addr, m_rd_src, m_credit_err,
               m_stat_bypass, m_stat_cal, m_stat_pause
    );

endinterface

// File: rtl/pifo_root_credit_counter.sv
// Outstanding buffer-read credit counter: saturates at 0 and MAX_CREDITS, and flags
// (sticky) a returned credit that would overflow the pool.
module pifo_root_credit_counter
    import pifo_sched_pkg::*;
#(
    parameter int MAX_CREDITS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic dec_i,
    output logic zero_o,
    output logic full_o,
    output logic err_o
);

    localparam logic [CREDIT_WIDTH-1:0] MAX_CNT = CREDIT_WIDTH'(MAX_CREDITS);

    logic [CREDIT_WIDTH-1:0] cnt_q, cnt_d;
    logic                    err_q, err_d;

    // Next count; a simultaneous return and consume leaves the count unchanged
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (inc_i && !dec_i) begin
            if (cnt_q == MAX_CNT) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CREDIT_WIDTH'(1);
            end
        end else if (dec_i && !inc_i) begin
            if (cnt_q != {CREDIT_WIDTH{1'b0}}) begin
                cnt_d = cnt_q - CREDIT_WIDTH'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Credit and error state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= MAX_CNT;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign zero_o = (cnt_q == {CREDIT_WIDTH{1'b0}});
    assign full_o = (cnt_q == MAX_CNT);
    assign err_o  = err_q;

endmodule

// File: rtl/pifo_root_dequeue_scheduler.sv
// Root PIFO dequeue scheduler: routes each root entry to the buffer read slot or to calendar
// insert, and pops the calendar top when idle. Statistics counters exist only when
// PIFO_SCHED_STATS_EN is defined.
module pifo_root_dequeue_scheduler
    import pifo_sched_pkg::*;
#(
    parameter int MAX_CREDITS = 4,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    pifo_root_dequeue_scheduler_if.master  bus
);

    sched_state_e                 state_q, state_d;
    logic                         rd_valid_q, rd_valid_d;
    logic [BUFFER_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                         rd_src_q, rd_src_d;
    logic                         ins_full_q, ins_full_d;
    logic [PIFO_ROOT_WIDTH-1:0]   ins_info_q, ins_info_d;

    root_word_t top_s;
    logic       paused_s;
    logic       bypass_ready_s;
    logic       accept_s;
    logic       load_s;
    logic       pop_s;
    logic       rd_hs_s;
    logic       credit_zero_s;
    logic       credit_full_s;
    logic       credit_err_s;
    logic       unused_sink_s;

    assign top_s = root_word_t'(bus.s_cal_top);
    // The overflow bit travels with the entry but plays no part in dequeue decisions
    assign unused_sink_s = top_s.overflow ^ credit_full_s;

    // Routing and pop decisions; a bypass load always wins over a calendar pop
    always_comb begin
        paused_s       = rank_paused(bus.s_gpfc_valid, top_s.rank, bus.s_gpfc_pause_rank);
        bypass_ready_s = ~rst & (~ins_full_q | bus.s_cal_ins_ready);
        accept_s       = bus.s_bypass_valid & bypass_ready_s;
        load_s         = accept_s & bus.s_bypass_en & (state_q == ST_IDLE) & ~credit_zero_s;
        pop_s          = ~rst & (state_q == ST_IDLE) & ~load_s & top_s.valid
                         & ~credit_zero_s & ~paused_s;
        rd_hs_s        = rd_valid_q & bus.m_rd_ready;
    end

    // Insert register: drains on calendar ready, reloads with any accepted non-bypass entry
    always_comb begin
        ins_full_d = ins_full_q;
        ins_info_d = ins_info_q;
        if (accept_s && !load_s) begin
            ins_full_d = 1'b1;
            ins_info_d = bus.s_bypass_info;
        end else if (ins_full_q && bus.s_cal_ins_ready) begin
            ins_full_d = 1'b0;
        end else begin
            ins_full_d = ins_full_q;
        end
    end

    // Read-slot FSM; POP_WAIT gives the calendar one cycle to present its new top
    always_comb begin
        state_d    = state_q;
        rd_valid_d = rd_valid_q;
        rd_addr_d  = rd_addr_q;
        rd_src_d   = rd_src_q;
        case (state_q)
            ST_IDLE: begin
                if (load_s) begin
                    state_d    = ST_ISSUE;
                    rd_valid_d = 1'b1;
                    rd_addr_d  = bus.s_bypass_info[BUFFER_ADDR_WIDTH-1:0];
                    rd_src_d   = 1'b1;
                end else if (pop_s) begin
                    state_d    = ST_POP_WAIT;
                    rd_addr_d  = top_s.addr;
                    rd_src_d   = 1'b0;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_POP_WAIT: begin
                state_d    = ST_ISSUE;
                rd_valid_d = 1'b1;
            end
            ST_ISSUE: begin
                if (bus.m_rd_ready) begin
                    state_d    = ST_IDLE;
                    rd_valid_d = 1'b0;
                end else begin
                    state_d    = ST_ISSUE;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                rd_valid_d = 1'b0;
            end
        endcase
    end

    // Scheduler state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rd_valid_q <= 1'b0;
            rd_addr_q  <= {BUFFER_ADDR_WIDTH{1'b0}};
            rd_src_q   <= 1'b0;
            ins_full_q <= 1'b0;
            ins_info_q <= {PIFO_ROOT_WIDTH{1'b0}};
        end else begin
            state_q    <= state_d;
            rd_valid_q <= rd_valid_d;
            rd_addr_q  <= rd_addr_d;
            rd_src_q   <= rd_src_d;
            ins_full_q <= ins_full_d;
            ins_info_q <= ins_info_d;
        end
    end

    pifo_root_credit_counter #(
        .MAX_CREDITS (MAX_CREDITS)
    ) u_credits (
        .clk    (clk),
        .rst    (rst),
        .inc_i  (bus.s_rd_done),
        .dec_i  (rd_hs_s),
        .zero_o (credit_zero_s),
        .full_o (credit_full_s),
        .err_o  (credit_err_s)
    );

    assign bus.s_bypass_ready  = bypass_ready_s;
    assign bus.m_cal_pop       = pop_s;
    assign bus.m_cal_ins_valid = ins_full_q;
    assign bus.m_cal_ins_info  = ins_info_q;
    assign bus.m_rd_valid      = rd_valid_q;
    assign bus.m_rd_addr       = rd_addr_q;
    assign bus.m_rd_src        = rd_src_q;
    assign bus.m_credit_err    = credit_err_s;

`ifdef PIFO_SCHED_STATS_EN
    logic [CNT_WIDTH-1:0] stat_bypass_q, stat_bypass_d;
    logic [CNT_WIDTH-1:0] stat_cal_q, stat_cal_d;
    logic [CNT_WIDTH-1:0] stat_pause_q, stat_pause_d;
    logic                 stall_s;

    // Issues are counted at the read handshake; stalls on every paused idle cycle
    always_comb begin
        stall_s       = (state_q == ST_IDLE) & top_s.valid & paused_s;
        stat_bypass_d = stat_bypass_q;
        stat_cal_d    = stat_cal_q;
        stat_pause_d  = stat_pause_q;
        if (rd_hs_s && rd_src_q) begin
            stat_bypass_d = stat_bypass_q + CNT_WIDTH'(1);
        end else if (rd_hs_s) begin
            stat_cal_d = stat_cal_q + CNT_WIDTH'(1);
        end else begin
            stat_bypass_d = stat_bypass_q;
        end
        if (stall_s) begin
            stat_pause_d = stat_pause_q + CNT_WIDTH'(1);
        end else begin
            stat_pause_d = stat_pause_q;
        end
    end

    // Statistics registers, free-running and wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_bypass_q <= {CNT_WIDTH{1'b0}};
            stat_cal_q    <= {CNT_WIDTH{1'b0}};
            stat_pause_q  <= {CNT_WIDTH{1'b0}};
        end else begin
            stat_bypass_q <= stat_bypass_d;
            stat_cal_q    <= stat_cal_d;
            stat_pause_q  <= stat_pause_d;
        end
    end

    assign bus.m_stat_bypass = stat_bypass_q;
    assign bus.m_stat_cal    = stat_cal_q;
    assign bus.m_stat_pause  = stat_pause_q;
`else
    assign bus.m_stat_bypass = {CNT_WIDTH{1'b0}};
    assign bus.m_stat_cal    = {CNT_WIDTH{1'b0}};
    assign bus.m_stat_pause  = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_pifo_root_dequeue_scheduler.sv
// Directed self-checking bench for the root PIFO dequeue scheduler.
module tb_pifo_root_dequeue_scheduler;
    import pifo_sched_pkg::*;

`ifdef PIFO_SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    pifo_root_dequeue_scheduler_if #(.CNT_WIDTH(32)) bus ();

    pifo_root_dequeue_scheduler #(.MAX_CREDITS(4), .CNT_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mkword(input logic v, input logic [17:0] rank, input logic [11:0] addr);
        return {v, 1'b0, rank, addr};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.s_bypass_valid = 1'b1; bus.s_bypass_info = mkword(1'b1, 18'd0, 12'h0AA); bus.s_bypass_en = 1'b1;
        bus.s_cal_top = mkword(1'b1, 18'd0, 12'h0AB); bus.s_cal_ins_ready = 1'b1;
        bus.s_gpfc_valid = 1'b0; bus.s_gpfc_pause_rank = 18'd0; bus.m_rd_ready = 1'b1; bus.s_rd_done = 1'b0;
        repeat (2) tick();
        checks++; if (bus.m_rd_valid !== 1'b0) begin errors++; $display("FAIL rst_rd_valid got %0h exp 0", bus.m_rd_valid); end
        checks++; if (bus.m_rd_addr !== 12'h000) begin errors++; $display("FAIL rst_rd_addr got %0h exp 0", bus.m_rd_addr); end
        checks++; if (bus.m_cal_pop !== 1'b0) begin errors++; $display("FAIL rst_pop got %0h exp 0", bus.m_cal_pop); end
        checks++; if (bus.s_bypass_ready !== 1'b0) begin errors++; $display("FAIL rst_bypass_ready got %0h exp 0", bus.s_bypass_ready); end
        checks++; if (bus.m_cal_ins_valid !== 1'b0) begin errors++; $display("FAIL rst_ins_valid got %0h exp 0", bus.m_cal_ins_valid); end
        checks++; if (bus.m_credit_err !== 1'b0) begin errors++; $display("FAIL rst_credit_err got %0h exp 0", bus.m_credit_err); end
        checks++; if (bus.m_stat_bypass !== 32'd0) begin errors++; $display("FAIL rst_stat_bypass got %0h exp 0", bus.m_stat_bypass); end
        rst = 1'b0;
        bus.s_bypass_valid = 1'b0; bus.s_bypass_en = 1'b0; bus.s_bypass_info = 32'd0; bus.s_cal_top = 32'd0;
        tick();
    endtask

    task automatic test_bypass();
        bus.s_bypass_valid = 1'b1; bus.s_bypass_en = 1'b1; bus.s_bypass_info = mkword(1'b1, 18'd3, 12'h010);
        #1;
        checks++; if (bus.s_bypass_ready !== 1'b1) begin errors++; $display("FAIL byp_ready got %0h exp 1", bus.s_bypass_ready); end
        checks++; if (bus.m_rd_valid !== 1'b0) begin errors++; $display("FAIL byp_latency got %0h exp 0", bus.m_rd_valid); end
        tick();
        bus.s_bypass_valid = 1'b0; bus.s_bypass_en = 1'b0; bus.s_bypass_info = 32'd0;
        #1;
        checks++; if (bus.m_rd_valid !== 1'b1) begin errors++; $display("FAIL byp_rd_valid got %0h exp 1", bus.m_rd_valid); end
        checks++; if (bus.m_rd_addr !== 12'h010) begin errors++; $display("FAIL byp_rd_addr got %0h exp 010", bus.m_rd_addr); end
        checks++; if (bus.m_rd_src !== 1'b1) begin errors++; $display("FAIL byp_rd_src got %0h exp 1", bus.m_rd_src); end
        checks++; if (bus.m_cal_pop !== 1'b0) begin errors++; $display("FAIL byp_no_pop got %0h exp 0", bus.m_cal_pop); end
        tick();
        checks++; if (bus.m_rd_valid !== 1'b0) begin errors++; $display("FAIL byp_hs_done got %0h exp 0", bus.m_rd_valid); end
        bus.s_rd_done = 1'b1; tick(); bus.s_rd_done = 1'b0;
    endtask

    task automatic test_cal_pop();
        bus.s_cal_top = mkword(1'b1, 18'd5, 12'h020);
        #1;
        checks++; if (bus.m_cal_pop !== 1'b1) begin errors++; $display("FAIL cal_pop got %0h exp 1", bus.m_cal_pop); end
        tick();
        #1;
        checks++; if (bus.m_cal_pop !== 1'b0) begin errors++; $display("FAIL cal_no_double_pop got %0h exp 0", bus.m_cal_pop); end
        checks++; if (bus.m_rd_valid !== 1'b0) begin errors++; $display("FAIL cal_pop_wait got %0h exp 0", bus.m_rd_valid); end
        tick();
        bus.s_cal_top = 32'd0;
        #1;
        checks++; if (bus.m_rd_valid !== 1'b1) begin errors++; $display("FAIL cal_rd_valid got %0h exp 1", bus.m_rd_valid); end
        checks++; if (bus.m_rd_addr !== 12'h020) begin errors++; $display("FAIL cal_rd_addr got %0h exp 020", bus.m_rd_addr); end
        checks++; if (bus.m_rd_src !== 1'b0) begin errors++; $display("FAIL cal_rd_src got %0h exp 0", bus.m_rd_src); end
        tick();
        bus.s_rd_done = 1'b1; tick(); bus.s_rd_done = 1'b0;
    endtask

    task automatic test_pause();
        bus.s_gpfc_valid = 1'b1; bus.s_gpfc_pause_rank = 18'd5; bus.s_cal_top = mkword(1'b1, 18'd7, 12'h030);
        #1;
        checks++; if (bus.m_cal_pop !== 1'b0) begin errors++; $display("FAIL pause_gt got %0h exp 0", bus.m_cal_pop); end
        tick();
        tick();
        checks++; if (bus.m_cal_pop !== 1'b0) begin errors++; $display("FAIL pause_hold got %0h exp 0", bus.m_cal_pop); end
        bus.s_cal_top = mkword(1'b1, 18'd5, 12'h030);
        #1;
        checks++; if (bus.m_cal_pop !== 1'b0) begin errors++; $display("FAIL pause_eq got %0h exp 0", bus.m_cal_pop); end
        tick();
        bus.s_gpfc_valid = 1'b0;
        #1;
        checks++; if (bus.m_cal_pop !== 1'b1) begin errors++; $display("FAIL pause_release got %0h exp 1", bus.m_cal_pop); end
        tick();
        tick();
        bus.s_cal_top = 32'd0;
        #1;
        checks++; if (bus.m_rd_addr !== 12'h030) begin errors++; $display("FAIL pause_rd_addr got %0h exp 030", bus.m_rd_addr); end
        checks++; if (bus.m_rd_valid !== 1'b1) begin errors++; $display("FAIL pause_rd_valid got %0h exp 1", bus.m_rd_valid); end
        tick();
        checks++; if (bus.m_stat_pause !== (STATS ? 32'd3 : 32'd0)) begin errors++; $display("FAIL stat_pause got %0d exp %0d", bus.m_stat_pause, STATS ? 3 : 0); end
        checks++; if (bus.m_stat_cal !== (STATS ? 32'd2 : 32'd0)) begin errors++; $display("FAIL stat_cal got %0d exp %0d", bus.m_stat_cal, STATS ? 2 : 0); end
        checks++; if (bus.m_stat_bypass !== (STATS ? 32'd1 : 32'd0)) begin errors++; $display("FAIL stat_bypass got %0d exp %0d", bus.m_stat_bypass, STATS ? 1 : 0); end
        bus.s_rd_done = 1'b1; tick(); bus.s_rd_done = 1'b0;
    endtask

    task automatic test_credits();
        logic [11:0] ea;
        for (int i = 0; i < 4; i++) begin
            ea = 12'h040 + 12'(i);
            bus.s_bypass_valid = 1'b1; bus.s_bypass_en = 1'b1; bus.s_bypass_info = mkword(1'b1, 18'd2, ea);
            tick();
            bus.s_bypass_valid = 1'b0; bus.s_bypass_en = 1'b0;
            #1;
            checks++; if (bus.m_rd_addr !== ea) begin errors++; $display("FAIL cred_rd_addr%0d got %0h exp %0h", i, bus.m_rd_addr, ea); end
            tick();
        end
        bus.s_bypass_valid = 1'b1; bus.s_bypass_en = 1'b1; bus.s_bypass_info = mkword(1'b1, 18'd2, 12'h050);
        tick();
        bus.s_bypass_valid = 1'b0; bus.s_bypass_en = 1'b0; bus.s_cal_top = mkword(1'b1, 18'd1, 12'h060);
        #1;
        checks++; if (bus.m_rd_valid !== 1'b0) begin errors++; $display("FAIL cred_zero_no_issue got %0h exp 0", bus.m_rd_valid); end
        checks++; if (bus.m_cal_ins_valid !== 1'b1) begin errors++; $display("FAIL cred_zero_ins_valid got %0h exp 1", bus.m_cal_ins_valid); end
        checks++; if (bus.m_cal_ins_info !== mkword(1'b1, 18'd2, 12'h050)) begin errors++; $display("FAIL cred_zero_ins_info got %0h exp %0h", bus.m_cal_ins_info, mkword(1'b1, 18'd2, 12'h050)); end
        checks++; if (bus.m_cal_pop !== 1'b0) begin errors++; $display("FAIL cred_zero_no_pop got %0h exp 0", bus.m_cal_pop); end
        tick();
        checks++; if (bus.m_cal_ins_valid !== 1'b0) begin errors++; $display("FAIL cred_ins_drain got %0h exp 0", bus.m_cal_ins_valid); end
        bus.s_rd_done = 1'b1; tick(); bus.s_rd_done = 1'b0;
        #1;
        checks++; if (bus.m_cal_pop !== 1'b1) begin errors++; $display("FAIL cred_restore_pop got %0h exp 1", bus.m_cal_pop); end
        tick();
        tick();
        bus.s_cal_top = 32'd0;
        #1;
        checks++; if (bus.m_rd_addr !== 12'h060) begin errors++; $display("FAIL cred_restore_addr got %0h exp 060", bus.m_rd_addr); end
        tick();
        bus.s_rd_done = 1'b1; repeat (4) tick(); bus.s_rd_done = 1'b0;
        checks++; if (bus.m_credit_err !== 1'b0) begin errors++; $display("FAIL cred_no_err got %0h exp 0", bus.m_credit_err); end
    endtask

    task automatic test_ins_hold();
        bus.s_cal_ins_ready = 1'b0;
        bus.s_bypass_valid = 1'b1; bus.s_bypass_en = 1'b0; bus.s_bypass_info = mkword(1'b1, 18'd9, 12'h070);
        #1;
        checks++; if (bus.s_bypass_ready !== 1'b1) begin errors++; $display("FAIL ins_empty_ready got %0h exp 1", bus.s_bypass_ready); end
        tick();
        bus.s_bypass_info = mkword(1'b1, 18'd9, 12'h071);
        #1;
        checks++; if (bus.s_bypass_ready !== 1'b0) begin errors++; $display("FAIL ins_full_ready got %0h exp 0", bus.s_bypass_ready); end
        checks++; if (bus.m_rd_valid !== 1'b0) begin errors++; $display("FAIL ins_en0_no_issue got %0h exp 0", bus.m_rd_valid); end
        tick();
        checks++; if (bus.m_cal_ins_info !== mkword(1'b1, 18'd9, 12'h070)) begin errors++; $display("FAIL ins_held got %0h exp %0h", bus.m_cal_ins_info, mkword(1'b1, 18'd9, 12'h070)); end
        bus.s_cal_ins_ready = 1'b1;
        #1;
        checks++; if (bus.s_bypass_ready !== 1'b1) begin errors++; $display("FAIL ins_ready_pass got %0h exp 1", bus.s_bypass_ready); end
        tick();
        bus.s_bypass_valid = 1'b0;
        #1;
        checks++; if (bus.m_cal_ins_info !== mkword(1'b1, 18'd9, 12'h071)) begin errors++; $display("FAIL ins_second got %0h exp %0h", bus.m_cal_ins_info, mkword(1'b1, 18'd9, 12'h071)); end
        tick();
        checks++; if (bus.m_cal_ins_valid !== 1'b0) begin errors++; $display("FAIL ins_final_drain got %0h exp 0", bus.m_cal_ins_valid); end
    endtask

    task automatic test_priority();
        bus.s_cal_top = mkword(1'b1, 18'd1, 12'h0A0);
        bus.s_bypass_valid = 1'b1; bus.s_bypass_en = 1'b1; bus.s_bypass_info = mkword(1'b1, 18'd1, 12'h0B0);
        #1;
        checks++; if (bus.m_cal_pop !== 1'b0) begin errors++; $display("FAIL prio_no_pop got %0h exp 0", bus.m_cal_pop); end
        tick();
        bus.s_bypass_valid = 1'b0; bus.s_bypass_en = 1'b0;
        #1;
        checks++; if (bus.m_rd_addr !== 12'h0B0) begin errors++; $display("FAIL prio_byp_addr got %0h exp 0b0", bus.m_rd_addr); end
        tick();
        #1;
        checks++; if (bus.m_cal_pop !== 1'b1) begin errors++; $display("FAIL prio_then_pop got %0h exp 1", bus.m_cal_pop); end
        tick();
        tick();
        bus.s_cal_top = 32'd0;
        #1;
        checks++; if (bus.m_rd_addr !== 12'h0A0) begin errors++; $display("FAIL prio_cal_addr got %0h exp 0a0", bus.m_rd_addr); end
        tick();
        bus.s_rd_done = 1'b1; repeat (2) tick(); bus.s_rd_done = 1'b0;
    endtask

    task automatic test_reset_mid_issue();
        bus.s_bypass_valid = 1'b1; bus.s_bypass_en = 1'b1; bus.s_bypass_info = mkword(1'b1, 18'd0, 12'h0C0);
        tick();
        bus.s_bypass_valid = 1'b0; bus.s_bypass_en = 1'b0;
        tick();
        bus.m_rd_ready = 1'b0;
        bus.s_bypass_valid = 1'b1; bus.s_bypass_en = 1'b1; bus.s_bypass_info = mkword(1'b1, 18'd0, 12'h0C1);
        tick();
        bus.s_bypass_valid = 1'b0; bus.s_bypass_en = 1'b0;
        tick();
        checks++; if (bus.m_rd_valid !== 1'b1 || bus.m_rd_addr !== 12'h0C1) begin errors++; $display("FAIL stall_hold got %0h/%0h exp 1/0c1", bus.m_rd_valid, bus.m_rd_addr); end
        bus.s_cal_top = mkword(1'b1, 18'd1, 12'h0D0);
        rst = 1'b1;
        #1;
        checks++; if (bus.m_rd_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_rd_valid got %0h exp 0", bus.m_rd_valid); end
        checks++; if (bus.m_rd_src !== 1'b0) begin errors++; $display("FAIL mid_rst_rd_src got %0h exp 0", bus.m_rd_src); end
        checks++; if (bus.m_cal_pop !== 1'b0) begin errors++; $display("FAIL mid_rst_pop got %0h exp 0", bus.m_cal_pop); end
        checks++; if (bus.s_bypass_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_bypass_ready got %0h exp 0", bus.s_bypass_ready); end
        checks++; if (bus.m_stat_bypass !== 32'd0) begin errors++; $display("FAIL mid_rst_stat got %0h exp 0", bus.m_stat_bypass); end
        tick();
        rst = 1'b0; bus.s_cal_top = 32'd0; bus.m_rd_ready = 1'b1;
        #1;
        checks++; if (bus.m_credit_err !== 1'b0) begin errors++; $display("FAIL err_before got %0h exp 0", bus.m_credit_err); end
        bus.s_rd_done = 1'b1; tick(); bus.s_rd_done = 1'b0;
        #1;
        checks++; if (bus.m_credit_err !== 1'b1) begin errors++; $display("FAIL err_at_full got %0h exp 1", bus.m_credit_err); end
        tick();
        checks++; if (bus.m_credit_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %0h exp 1", bus.m_credit_err); end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_cal_pop();
        test_pause();
        test_credits();
        test_ins_hold();
        test_priority();
        test_reset_mid_issue();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
